// File: rtl/writeback_pkg.sv
// Shared writeback-stage types: WB mux select encoding, load funct3 codes, default width.
package writeback_pkg;

    localparam int XLEN_DEFAULT = 32;

    typedef enum logic [1:0] {
        WB_ALURESULT = 2'b00,
        WB_READDATA  = 2'b01,
        WB_PCPLUS    = 2'b10
    } wb_sel_e;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/writeback_arbiter_load_align.sv
// Load-data alignment: selects the byte/half lane from the raw memory word and extends it.
module load_align
    import writeback_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic [XLEN-1:0] rdata,
    input  logic [1:0]      offset,
    input  logic [2:0]      funct3,
    output logic [XLEN-1:0] data,
    output logic            illegal
);

    logic [XLEN-1:0] byte_shift;
    logic [XLEN-1:0] half_shift;
    logic [7:0]      byte_lane;
    logic [15:0]     half_lane;

    // Lane select ignores misalignment: the offset bits only pick which lane is returned.
    always_comb begin
        byte_shift = rdata >> {offset, 3'b000};
        half_shift = rdata >> {offset[1], 4'b0000};
        byte_lane  = byte_shift[7:0];
        half_lane  = half_shift[15:0];
        illegal    = 1'b0;
        data       = '0;
        case (funct3)
            F3_LB:   data = {{(XLEN-8){byte_lane[7]}}, byte_lane};
            F3_LH:   data = {{(XLEN-16){half_lane[15]}}, half_lane};
            F3_LW:   data = rdata;
            F3_LBU:  data = {{(XLEN-8){1'b0}}, byte_lane};
            F3_LHU:  data = {{(XLEN-16){1'b0}}, half_lane};
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/writeback_arbiter.sv
// Writeback stage: arbitrates MEM (source 0) against long-latency units with ageing,
// formats source-0 results and registers a single register-file write port.
module writeback_arbiter
    import writeback_pkg::*;
#(
    parameter int XLEN     = XLEN_DEFAULT,
    parameter int NUM_SRC  = 3,
    parameter int MAX_WAIT = 4,
    parameter int CNT_W    = 32
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic [NUM_SRC-1:0]             src_valid_i,
    output logic [NUM_SRC-1:0]             src_ready_o,
    input  logic [NUM_SRC-1:0]             src_regen_i,
    input  logic [NUM_SRC-1:0][4:0]        src_rd_addr_i,
    input  logic [NUM_SRC-1:0][XLEN-1:0]   src_data_i,
    input  logic [1:0]                     s0_wbsel_i,
    input  logic [XLEN-1:0]                s0_alu_i,
    input  logic [XLEN-1:0]                s0_rdata_i,
    input  logic [XLEN-1:0]                s0_pcplus_i,
    input  logic [2:0]                     s0_funct3_i,
    output logic                           decode_regen_o,
    output logic [4:0]                     decode_rd_addr_o,
    output logic [XLEN-1:0]                decode_rd_o,
    output logic [CNT_W-1:0]               retire_cnt_o,
    output logic                           wb_err_o
);

    localparam int AGE_W = $clog2(MAX_WAIT + 1);
    localparam int PTR_W = $clog2(NUM_SRC);

    logic [AGE_W-1:0]  age_reg [1:NUM_SRC-1];
    logic [PTR_W-1:0]  rr_reg;
    logic [PTR_W-1:0]  grant_idx;
    logic              grant_any;
    logic [NUM_SRC-1:0] grant_vec;

    logic [XLEN-1:0]   la_data;
    logic              la_illegal;
    logic              sel_regen;
    logic [4:0]        sel_addr;
    logic [XLEN-1:0]   sel_data;
    logic              sel_illegal;

    // Source 0 payload is formatted here; its src_data_i slot carries nothing.
    logic unused_src0_data;
    assign unused_src0_data = ^src_data_i[0];

    load_align #(.XLEN(XLEN)) u_load_align (
        .rdata   (s0_rdata_i),
        .offset  (s0_alu_i[1:0]),
        .funct3  (s0_funct3_i),
        .data    (la_data),
        .illegal (la_illegal)
    );

    // Grant priority: starved secondary (lowest index), then MEM, then round-robin secondaries.
    always_comb begin
        int idx;
        grant_any = 1'b0;
        grant_idx = '0;
        for (int i = NUM_SRC - 1; i >= 1; i--) begin
            if (src_valid_i[i] && (age_reg[i] >= AGE_W'(MAX_WAIT))) begin
                grant_any = 1'b1;
                grant_idx = PTR_W'(i);
            end
        end
        if (!grant_any && src_valid_i[0]) begin
            grant_any = 1'b1;
            grant_idx = '0;
        end
        for (int k = 0; k < NUM_SRC - 1; k++) begin
            idx = ((int'(rr_reg) - 1 + k) % (NUM_SRC - 1)) + 1;
            if (!grant_any && src_valid_i[idx]) begin
                grant_any = 1'b1;
                grant_idx = PTR_W'(idx);
            end
        end
    end

    // One-hot ready, forced low while reset is asserted.
    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_ready
        assign grant_vec[gi]   = grant_any && (grant_idx == PTR_W'(gi));
        assign src_ready_o[gi] = rst_ni && grant_vec[gi];
    end

    // Select the granted payload; illegal source-0 encodings yield zero data and no write.
    always_comb begin
        sel_regen   = 1'b0;
        sel_addr    = src_rd_addr_i[grant_idx];
        sel_data    = '0;
        sel_illegal = 1'b0;
        if (grant_idx == '0) begin
            case (s0_wbsel_i)
                WB_ALURESULT: sel_data = s0_alu_i;
                WB_PCPLUS:    sel_data = s0_pcplus_i;
                WB_READDATA: begin
                    sel_data    = la_illegal ? '0 : la_data;
                    sel_illegal = la_illegal;
                end
                default:      sel_illegal = 1'b1;
            endcase
            sel_regen = src_regen_i[0] && !sel_illegal;
        end else begin
            sel_regen = src_regen_i[grant_idx];
            sel_data  = src_data_i[grant_idx];
        end
    end

    // Ageing of waiting secondaries and round-robin pointer update.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 1; i < NUM_SRC; i++) age_reg[i] <= '0;
            rr_reg <= PTR_W'(1);
        end else begin
            for (int i = 1; i < NUM_SRC; i++) begin
                if (!src_valid_i[i] || grant_vec[i])
                    age_reg[i] <= '0;
                else if (age_reg[i] < AGE_W'(MAX_WAIT))
                    age_reg[i] <= age_reg[i] + AGE_W'(1);
            end
            if (grant_any && (grant_idx != '0))
                rr_reg <= (grant_idx == PTR_W'(NUM_SRC - 1)) ? PTR_W'(1) : grant_idx + PTR_W'(1);
        end
    end

    // Registered write port, retire counter and sticky error flag.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            decode_regen_o   <= 1'b0;
            decode_rd_addr_o <= '0;
            decode_rd_o      <= '0;
            retire_cnt_o     <= '0;
            wb_err_o         <= 1'b0;
        end else if (grant_any) begin
            decode_regen_o   <= sel_regen && (sel_addr != 5'd0);
            decode_rd_addr_o <= sel_addr;
            decode_rd_o      <= sel_data;
            retire_cnt_o     <= retire_cnt_o + CNT_W'(1);
            if (sel_illegal) wb_err_o <= 1'b1;
        end else begin
            decode_regen_o   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_writeback_arbiter.sv
// Scoreboard bench for writeback_arbiter: directed load-align, arbitration, ageing,
// round-robin, illegal-encoding and reset cases.
module tb_writeback_arbiter;

    logic                  clk_i = 1'b0;
    logic                  rst_ni;
    logic [2:0]            src_valid_i;
    logic [2:0]            src_ready_o;
    logic [2:0]            src_regen_i;
    logic [2:0][4:0]       src_rd_addr_i;
    logic [2:0][31:0]      src_data_i;
    logic [1:0]            s0_wbsel_i;
    logic [31:0]           s0_alu_i;
    logic [31:0]           s0_rdata_i;
    logic [31:0]           s0_pcplus_i;
    logic [2:0]            s0_funct3_i;
    logic                  decode_regen_o;
    logic [4:0]            decode_rd_addr_o;
    logic [31:0]           decode_rd_o;
    logic [31:0]           retire_cnt_o;
    logic                  wb_err_o;

    typedef struct {
        logic        regen;
        logic [4:0]  addr;
        logic [31:0] data;
        logic        chk_pl;
    } exp_t;

    exp_t        sb[$];
    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] cnt_model = 0;
    logic        err_model = 0;

    always #5 clk_i = ~clk_i;

    writeback_arbiter #(.XLEN(32), .NUM_SRC(3), .MAX_WAIT(4), .CNT_W(32)) dut (
        .clk_i            (clk_i),
        .rst_ni           (rst_ni),
        .src_valid_i      (src_valid_i),
        .src_ready_o      (src_ready_o),
        .src_regen_i      (src_regen_i),
        .src_rd_addr_i    (src_rd_addr_i),
        .src_data_i       (src_data_i),
        .s0_wbsel_i       (s0_wbsel_i),
        .s0_alu_i         (s0_alu_i),
        .s0_rdata_i       (s0_rdata_i),
        .s0_pcplus_i      (s0_pcplus_i),
        .s0_funct3_i      (s0_funct3_i),
        .decode_regen_o   (decode_regen_o),
        .decode_rd_addr_o (decode_rd_addr_o),
        .decode_rd_o      (decode_rd_o),
        .retire_cnt_o     (retire_cnt_o),
        .wb_err_o         (wb_err_o)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic drive_s0(input logic [1:0] sel, input logic [2:0] f3, input logic [31:0] alu,
                            input logic [31:0] rd, input logic [4:0] addr, input logic regen);
        src_valid_i[0]   = 1'b1;
        s0_wbsel_i       = sel;
        s0_funct3_i      = f3;
        s0_alu_i         = alu;
        s0_rdata_i       = rd;
        src_rd_addr_i[0] = addr;
        src_regen_i[0]   = regen;
    endtask

    // Called just after a rising edge with inputs set: checks ready, pushes the expected
    // result, advances one clock and pops/compares the registered output.
    task automatic apply(input string tag, input logic [2:0] exp_ready, input logic exp_regen,
                         input logic [4:0] exp_addr, input logic [31:0] exp_data,
                         input logic chk_pl, input logic sets_err);
        exp_t e;
        #1;
        check({tag, "_ready"}, src_ready_o, exp_ready);
        e.regen = exp_regen; e.addr = exp_addr; e.data = exp_data; e.chk_pl = chk_pl;
        sb.push_back(e);
        @(posedge clk_i);
        #1;
        if (exp_ready != 3'b000) cnt_model = cnt_model + 1;
        if (sets_err) err_model = 1'b1;
        e = sb.pop_front();
        check({tag, "_regen"}, decode_regen_o, e.regen);
        if (e.chk_pl) begin
            check({tag, "_addr"}, decode_rd_addr_o, e.addr);
            check({tag, "_data"}, decode_rd_o, e.data);
        end
        check({tag, "_cnt"}, retire_cnt_o, cnt_model);
        check({tag, "_err"}, wb_err_o, err_model);
        $display("txn %s ready=%b regen=%b addr=%0d data=%h cnt=%0d err=%b", tag, src_ready_o,
                 decode_regen_o, decode_rd_addr_o, decode_rd_o, retire_cnt_o, wb_err_o);
    endtask

    // Asynchronous reset pulse issued away from the clock edge; outputs must clear at once.
    task automatic pulse_reset(input string tag);
        rst_ni = 1'b0;
        #1;
        check({tag, "_rst_regen"}, decode_regen_o, 1'b0);
        check({tag, "_rst_addr"}, decode_rd_addr_o, 5'd0);
        check({tag, "_rst_data"}, decode_rd_o, 32'd0);
        check({tag, "_rst_cnt"}, retire_cnt_o, 32'd0);
        check({tag, "_rst_err"}, wb_err_o, 1'b0);
        check({tag, "_rst_ready"}, src_ready_o, 3'b000);
        @(posedge clk_i);
        #1;
        rst_ni    = 1'b1;
        cnt_model = 0;
        err_model = 1'b0;
        sb.delete();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_ni        = 1'b0;
        src_valid_i   = 3'b011;
        src_regen_i   = 3'b111;
        src_rd_addr_i[0] = 5'd7;
        src_rd_addr_i[1] = 5'd5;
        src_rd_addr_i[2] = 5'd6;
        src_data_i[0] = 32'hDEAD_BEEF;
        src_data_i[1] = 32'h1111_0001;
        src_data_i[2] = 32'h2222_0002;
        s0_wbsel_i    = 2'b00;
        s0_alu_i      = 32'h0000_00A0;
        s0_rdata_i    = 32'h0;
        s0_pcplus_i   = 32'h0000_1004;
        s0_funct3_i   = 3'b010;
        #2;
        check("reset_regen", decode_regen_o, 1'b0);
        check("reset_addr", decode_rd_addr_o, 5'd0);
        check("reset_data", decode_rd_o, 32'd0);
        check("reset_cnt", retire_cnt_o, 32'd0);
        check("reset_err", wb_err_o, 1'b0);
        check("reset_ready", src_ready_o, 3'b000);
        @(posedge clk_i); @(posedge clk_i); #1;
        src_valid_i = 3'b000;
        rst_ni = 1'b1;

        // Source-0 formatting.
        drive_s0(2'b01, 3'b000, 32'h0000_0002, 32'h80FF_7F01, 5'd3, 1'b1);
        apply("lb_off2", 3'b001, 1'b1, 5'd3, 32'hFFFF_FFFF, 1'b1, 1'b0);
        drive_s0(2'b01, 3'b101, 32'h0000_0002, 32'h8001_1234, 5'd4, 1'b1);
        apply("lhu_hi", 3'b001, 1'b1, 5'd4, 32'h0000_8001, 1'b1, 1'b0);
        drive_s0(2'b01, 3'b010, 32'h0000_0000, 32'h8001_1234, 5'd4, 1'b1);
        apply("lw", 3'b001, 1'b1, 5'd4, 32'h8001_1234, 1'b1, 1'b0);
        drive_s0(2'b01, 3'b001, 32'h0000_0000, 32'h8001_F234, 5'd8, 1'b1);
        apply("lh_lo", 3'b001, 1'b1, 5'd8, 32'hFFFF_F234, 1'b1, 1'b0);
        drive_s0(2'b01, 3'b100, 32'h0000_0003, 32'h80FF_7F01, 5'd9, 1'b1);
        apply("lbu_off3", 3'b001, 1'b1, 5'd9, 32'h0000_0080, 1'b1, 1'b0);
        drive_s0(2'b10, 3'b010, 32'h0000_00A0, 32'h0, 5'd1, 1'b1);
        apply("pcplus", 3'b001, 1'b1, 5'd1, 32'h0000_1004, 1'b1, 1'b0);
        drive_s0(2'b00, 3'b010, 32'h0000_00A0, 32'h0, 5'd0, 1'b1);
        apply("rd_zero", 3'b001, 1'b0, 5'd0, 32'h0000_00A0, 1'b1, 1'b0);

        // Idle cycle: no write, payload holds.
        src_valid_i = 3'b000;
        apply("idle", 3'b000, 1'b0, 5'd0, 32'h0000_00A0, 1'b1, 1'b0);

        // MEM against a starving unit: four MEM grants then the aged unit, twice.
        drive_s0(2'b00, 3'b010, 32'h0000_00A0, 32'h0, 5'd7, 1'b1);
        src_valid_i[1] = 1'b1;
        for (int r = 0; r < 2; r++) begin
            for (int c = 0; c < 4; c++)
                apply("age_s0", 3'b001, 1'b1, 5'd7, 32'h0000_00A0, 1'b1, 1'b0);
            apply("age_s1", 3'b010, 1'b1, 5'd5, 32'h1111_0001, 1'b1, 1'b0);
        end

        // Reset while sources are active, then round-robin between units from pointer 1.
        pulse_reset("mid");
        src_valid_i = 3'b110;
        for (int c = 0; c < 2; c++) begin
            apply("rr_s1", 3'b010, 1'b1, 5'd5, 32'h1111_0001, 1'b1, 1'b0);
            apply("rr_s2", 3'b100, 1'b1, 5'd6, 32'h2222_0002, 1'b1, 1'b0);
        end

        // Undefined load funct3: zero data, no write, sticky error.
        src_valid_i = 3'b000;
        drive_s0(2'b01, 3'b011, 32'h0, 32'h1234_5678, 5'd9, 1'b1);
        apply("bad_f3", 3'b001, 1'b0, 5'd9, 32'h0, 1'b1, 1'b1);
        src_valid_i = 3'b000;
        apply("err_hold", 3'b000, 1'b0, 5'd9, 32'h0, 1'b1, 1'b0);

        // Illegal wbsel after a fresh reset.
        pulse_reset("pre_sel");
        drive_s0(2'b11, 3'b010, 32'h0000_00A0, 32'h0, 5'd10, 1'b1);
        apply("bad_sel", 3'b001, 1'b0, 5'd10, 32'h0, 1'b1, 1'b1);
        drive_s0(2'b00, 3'b010, 32'h0000_00B0, 32'h0, 5'd11, 1'b1);
        apply("after_err", 3'b001, 1'b1, 5'd11, 32'h0000_00B0, 1'b1, 1'b0);
        src_valid_i = 3'b000;
        pulse_reset("final");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
